exc_vector_fetch: RTL and testbench



---
 rtl/exc_vector_fetch.sv | 125 ++++++++++++
 tb/tb_exc_vector_fetch.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/exc_vector_fetch.sv
// Exception vector fetch: selects vector address 253/254/255, captures handler byte, pulses a PC load.
// Latency: accept -> pc_load after MEM_LATENCY+1 edges; busy clears one edge later.
// No backpressure: requests arriving outside IDLE are dropped. Macro EXC_VECTOR_EPC_EN builds the EPC capture path.
module exc_vector_fetch #(
  // Edges from select code registered to memory data valid; legal range 1..15.
  parameter int unsigned MEM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        exc_req,
  input  logic [1:0]  exc_cause,
  input  logic [31:0] pc_in,
  input  logic [31:0] mem_data_in,
  output logic [3:0]  mem_addr_sel,
  output logic        busy,
  output logic [31:0] pc_out,
  output logic        pc_load,
  output logic [31:0] epc_out,
  output logic        epc_load,
  output logic        exc_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [3:0] LAT = 4'(MEM_LATENCY);

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic [3:0]  sel_nxt;
  logic [31:0] pc_nxt;
  logic        pc_load_nxt;
  logic        exc_err_nxt;
  logic        accept;

  // Register state, countdown, select code and PC outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      cnt          <= 4'd0;
      mem_addr_sel <= 4'd0;
      pc_out       <= 32'd0;
      pc_load      <= 1'b0;
      exc_err      <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      mem_addr_sel <= sel_nxt;
      pc_out       <= pc_nxt;
      pc_load      <= pc_load_nxt;
      exc_err      <= exc_err_nxt;
    end
  end

  // Next-state and next-output decode; select code is held through WAIT.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    sel_nxt     = mem_addr_sel;
    pc_nxt      = pc_out;
    pc_load_nxt = 1'b0;
    exc_err_nxt = 1'b0;
    accept      = 1'b0;
    case (state)
      S_IDLE: begin
        if (exc_req) begin
          if (exc_cause != 2'd3) begin
            accept    = 1'b1;
            sel_nxt   = 4'd2 + {2'b00, exc_cause};
            cnt_nxt   = LAT;
            state_nxt = S_WAIT;
          end else begin
            exc_err_nxt = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (cnt != 4'd0) begin
          cnt_nxt = cnt - 4'd1;
        end else begin
          pc_nxt      = {24'b0, mem_data_in[7:0]};
          pc_load_nxt = 1'b1;
          sel_nxt     = 4'd0;
          state_nxt   = S_DONE;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  assign busy = (state != S_IDLE);

`ifdef EXC_VECTOR_EPC_EN
  logic unused_bits;
  assign unused_bits = ^mem_data_in[31:8];

  // Capture the faulting PC on accept and strobe the EPC register for one cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      epc_out  <= 32'd0;
      epc_load <= 1'b0;
    end else begin
      epc_load <= accept;
      if (accept) begin
        epc_out <= pc_in;
      end
    end
  end
`else
  logic unused_bits;
  assign unused_bits = ^{pc_in, mem_data_in[31:8], accept};

  assign epc_out  = 32'd0;
  assign epc_load = 1'b0;
`endif

endmodule

// File: tb/tb_exc_vector_fetch.sv
// Directed bench for exc_vector_fetch: one instance at MEM_LATENCY=1, one at MEM_LATENCY=4.
// Inputs change 1 time unit after a rising edge; outputs are sampled at that same point.
// EPC expectations follow whether EXC_VECTOR_EPC_EN is defined for the build.
module tb_exc_vector_fetch;

  logic        clk;
  logic        reset_n;
  logic        req1, req4;
  logic [1:0]  exc_cause;
  logic [31:0] pc_in;
  logic [31:0] mem_data_in;

  logic [3:0]  sel1, sel4;
  logic        busy1, busy4;
  logic [31:0] pc_out1, pc_out4;
  logic        pc_load1, pc_load4;
  logic [31:0] epc_out1, epc_out4;
  logic        epc_load1, epc_load4;
  logic        exc_err1, exc_err4;

  int errors = 0;
  int checks = 0;

`ifdef EXC_VECTOR_EPC_EN
  localparam bit EPC = 1'b1;
`else
  localparam bit EPC = 1'b0;
`endif

  exc_vector_fetch #(.MEM_LATENCY(1)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .exc_req(req1), .exc_cause(exc_cause),
    .pc_in(pc_in), .mem_data_in(mem_data_in), .mem_addr_sel(sel1), .busy(busy1),
    .pc_out(pc_out1), .pc_load(pc_load1), .epc_out(epc_out1), .epc_load(epc_load1),
    .exc_err(exc_err1)
  );

  exc_vector_fetch #(.MEM_LATENCY(4)) u_dut4 (
    .clk(clk), .reset_n(reset_n), .exc_req(req4), .exc_cause(exc_cause),
    .pc_in(pc_in), .mem_data_in(mem_data_in), .mem_addr_sel(sel4), .busy(busy4),
    .pc_out(pc_out4), .pc_load(pc_load4), .epc_out(epc_out4), .epc_load(epc_load4),
    .exc_err(exc_err4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero1(input string tag);
    chk({tag, ".sel"}, {28'd0, sel1}, 32'd0);
    chk({tag, ".busy"}, {31'd0, busy1}, 32'd0);
    chk({tag, ".pc_out"}, pc_out1, 32'd0);
    chk({tag, ".pc_load"}, {31'd0, pc_load1}, 32'd0);
    chk({tag, ".epc_out"}, epc_out1, 32'd0);
    chk({tag, ".epc_load"}, {31'd0, epc_load1}, 32'd0);
    chk({tag, ".exc_err"}, {31'd0, exc_err1}, 32'd0);
  endtask

  initial begin
    reset_n     = 1'b0;
    req1        = 1'b0;
    req4        = 1'b0;
    exc_cause   = 2'd0;
    pc_in       = 32'd0;
    mem_data_in = 32'd0;

    // Reset state
    #3;
    chk_all_zero1("rst");
    chk("rst.busy4", {31'd0, busy4}, 32'd0);
    chk("rst.sel4", {28'd0, sel4}, 32'd0);
    edge1();
    edge1();
    reset_n = 1'b1;
    edge1();

    // Overflow on latency-1 instance
    req1 = 1'b1; exc_cause = 2'd1; pc_in = 32'h0000_0040; mem_data_in = 32'h0000_0A7C;
    edge1(); // E0
    req1 = 1'b0;
    chk("ovf.E0.sel", {28'd0, sel1}, 32'd3);
    chk("ovf.E0.busy", {31'd0, busy1}, 32'd1);
    chk("ovf.E0.epc_load", {31'd0, epc_load1}, {31'd0, EPC});
    chk("ovf.E0.epc_out", epc_out1, EPC ? 32'h40 : 32'h0);
    chk("ovf.E0.pc_load", {31'd0, pc_load1}, 32'd0);
    edge1(); // E1
    chk("ovf.E1.sel", {28'd0, sel1}, 32'd3);
    chk("ovf.E1.epc_load", {31'd0, epc_load1}, 32'd0);
    chk("ovf.E1.pc_load", {31'd0, pc_load1}, 32'd0);
    edge1(); // E2
    chk("ovf.E2.sel", {28'd0, sel1}, 32'd0);
    chk("ovf.E2.pc_load", {31'd0, pc_load1}, 32'd1);
    chk("ovf.E2.pc_out", pc_out1, 32'h0000_007C);
    chk("ovf.E2.busy", {31'd0, busy1}, 32'd1);
    edge1(); // E3
    chk("ovf.E3.pc_load", {31'd0, pc_load1}, 32'd0);
    chk("ovf.E3.busy", {31'd0, busy1}, 32'd0);
    chk("ovf.E3.pc_hold", pc_out1, 32'h0000_007C);
    chk("ovf.E3.epc_hold", epc_out1, EPC ? 32'h40 : 32'h0);

    // Divide-by-zero on latency-4 instance
    req4 = 1'b1; exc_cause = 2'd2; pc_in = 32'h0000_1234; mem_data_in = 32'h0000_01FF;
    edge1(); // E0
    req4 = 1'b0;
    chk("lat.E0.epc_out", epc_out4, EPC ? 32'h1234 : 32'h0);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) edge1();
      chk($sformatf("lat.E%0d.sel", i), {28'd0, sel4}, 32'd4);
      chk($sformatf("lat.E%0d.pc_load", i), {31'd0, pc_load4}, 32'd0);
    end
    edge1(); // E5
    chk("lat.E5.sel", {28'd0, sel4}, 32'd0);
    chk("lat.E5.pc_load", {31'd0, pc_load4}, 32'd1);
    chk("lat.E5.pc_out", pc_out4, 32'h0000_00FF);
    chk("lat.E5.busy", {31'd0, busy4}, 32'd1);
    edge1(); // E6
    chk("lat.E6.busy", {31'd0, busy4}, 32'd0);
    chk("lat.E6.pc_load", {31'd0, pc_load4}, 32'd0);

    // Reserved cause
    req1 = 1'b1; exc_cause = 2'd3; pc_in = 32'h0000_0999;
    edge1();
    req1 = 1'b0;
    chk("rsv.exc_err", {31'd0, exc_err1}, 32'd1);
    chk("rsv.busy", {31'd0, busy1}, 32'd0);
    chk("rsv.sel", {28'd0, sel1}, 32'd0);
    chk("rsv.pc_load", {31'd0, pc_load1}, 32'd0);
    chk("rsv.epc_load", {31'd0, epc_load1}, 32'd0);
    chk("rsv.epc_hold", epc_out1, EPC ? 32'h40 : 32'h0);
    edge1();
    chk("rsv.exc_err_clr", {31'd0, exc_err1}, 32'd0);

    // Requests during WAIT/DONE ignored; held request re-accepted at E(L+3)
    req1 = 1'b1; exc_cause = 2'd0; pc_in = 32'h0000_0100; mem_data_in = 32'hFFFF_FF33;
    edge1(); // E0
    chk("b2b.E0.sel", {28'd0, sel1}, 32'd2);
    req1 = 1'b0;
    edge1(); // E1
    req1 = 1'b1;
    chk("b2b.E1.sel", {28'd0, sel1}, 32'd2);
    chk("b2b.E1.exc_err", {31'd0, exc_err1}, 32'd0);
    chk("b2b.E1.epc_load", {31'd0, epc_load1}, 32'd0);
    edge1(); // E2
    chk("b2b.E2.pc_load", {31'd0, pc_load1}, 32'd1);
    chk("b2b.E2.pc_out", pc_out1, 32'h0000_0033);
    chk("b2b.E2.epc_load", {31'd0, epc_load1}, 32'd0);
    pc_in = 32'h0000_0200; mem_data_in = 32'h0000_0011;
    edge1(); // E3: DONE -> IDLE, request still high
    chk("b2b.E3.pc_load", {31'd0, pc_load1}, 32'd0);
    chk("b2b.E3.busy", {31'd0, busy1}, 32'd0);
    chk("b2b.E3.epc_load", {31'd0, epc_load1}, 32'd0);
    edge1(); // E4: second accept
    chk("b2b.E4.busy", {31'd0, busy1}, 32'd1);
    chk("b2b.E4.sel", {28'd0, sel1}, 32'd2);
    chk("b2b.E4.epc_out", epc_out1, EPC ? 32'h200 : 32'h0);
    exc_cause = 2'd3;
    edge1(); // E5: reserved cause while busy
    chk("b2b.E5.exc_err", {31'd0, exc_err1}, 32'd0);
    chk("b2b.E5.sel", {28'd0, sel1}, 32'd2);
    req1 = 1'b0;
    edge1(); // E6
    chk("b2b.E6.pc_load", {31'd0, pc_load1}, 32'd1);
    chk("b2b.E6.pc_out", pc_out1, 32'h0000_0011);
    edge1(); // E7
    chk("b2b.E7.busy", {31'd0, busy1}, 32'd0);

    // Reset in the middle of WAIT
    req1 = 1'b1; exc_cause = 2'd1; pc_in = 32'h0000_0055; mem_data_in = 32'h0000_0066;
    edge1(); // E0
    req1 = 1'b0;
    chk("mid.E0.sel", {28'd0, sel1}, 32'd3);
    #2;
    reset_n = 1'b0;
    #1;
    chk_all_zero1("mid.async");
    req1 = 1'b1; // accept attempt while reset held
    edge1();
    chk("mid.held.pc_load", {31'd0, pc_load1}, 32'd0);
    chk("mid.held.busy", {31'd0, busy1}, 32'd0);
    req1 = 1'b0;
    reset_n = 1'b1;
    edge1();
    chk("mid.post.busy", {31'd0, busy1}, 32'd0);
    chk("mid.post.pc_load", {31'd0, pc_load1}, 32'd0);
    chk("mid.post.pc_out", pc_out1, 32'd0);
    edge1();
    chk("mid.post2.pc_load", {31'd0, pc_load1}, 32'd0);

    // Fresh accept after reset works from IDLE
    req1 = 1'b1; exc_cause = 2'd2; mem_data_in = 32'h0000_00AB;
    edge1();
    req1 = 1'b0;
    chk("post.sel", {28'd0, sel1}, 32'd4);
    edge1();
    edge1();
    chk("post.pc_out", pc_out1, 32'h0000_00AB);
    chk("post.pc_load", {31'd0, pc_load1}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
